// File: rtl/svi_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module : R (interface)
// Brief  : Requester link between one producer and the round-robin scheduler.
// Rev    : 1.0  initial release
// ============================================================================
interface R #(
    parameter int W_DATA = 8
);
    logic              req;
    logic [W_DATA-1:0] data;
    logic              gnt;
    logic              ack;

    // S is the scheduler side, M the producer side.
    modport S (input req, input data, output gnt, output ack);
    modport M (output req, output data, input gnt, input ack);
endinterface
`default_nettype wire

// File: rtl/svi_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module : svi_rr_scheduler
// Brief  : Round-robin scheduler multiplexing N_REQ SVI producers onto one
//          valid/ready channel with a per-grant burst limit.
// Rev    : 1.0  initial release
// ============================================================================
module svi_rr_scheduler #(
    parameter int N_REQ     = 8,
    parameter int W_DATA    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    R.S                              p [N_REQ],
    output logic                     o_valid,
    output logic [W_DATA-1:0]        o_data,
    input  logic                     i_ready,
    output logic [$clog2(N_REQ)-1:0] o_owner,
    output logic                     o_busy
);

    localparam int c_OWN_W = $clog2(N_REQ);
    localparam int c_CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_GRANT = 1'b1;

    logic [0:0]         r_state;
    logic [c_OWN_W-1:0] r_owner;
    logic [c_OWN_W-1:0] r_ptr;
    logic [c_CNT_W-1:0] r_cnt;

    logic [N_REQ-1:0]   w_req;
    logic [W_DATA-1:0]  w_data [N_REQ];
    logic               w_grant;
    logic               w_own_req;
    logic               w_beat;
    logic               w_last;
    logic               w_release;
    logic [c_OWN_W-1:0] w_next_ptr;
    logic [c_OWN_W-1:0] w_base;
    logic [c_OWN_W-1:0] w_scan;
    logic [c_OWN_W-1:0] w_pick_idx;
    logic               w_pick_found;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_port
        assign w_req[gi]    = p[gi].req;
        assign w_data[gi]   = p[gi].data;
        assign p[gi].gnt    = w_grant && (r_owner == c_OWN_W'(gi));
        assign p[gi].ack    = w_beat  && (r_owner == c_OWN_W'(gi));
    end

    assign w_grant    = (r_state == c_ST_GRANT);
    assign w_own_req  = w_req[r_owner];
    assign w_beat     = w_grant && w_own_req && i_ready;
    assign w_last     = (r_cnt == c_CNT_W'(MAX_BURST - 1));
    assign w_release  = w_grant && (!w_own_req || (w_beat && w_last));
    assign w_next_ptr = (r_owner == c_OWN_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

    // On release the scan starts one past the old owner, so it sees the same
    // request vector as an idle arbitration would and wastes no cycle.
    assign w_base = w_grant ? w_next_ptr : r_ptr;

    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_scan       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_scan = c_OWN_W'((int'(w_base) + k) % N_REQ);
            if (w_req[w_scan]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_scan;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state <= c_ST_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else if (r_state == c_ST_IDLE) begin
            if (w_pick_found) begin
                r_owner <= w_pick_idx;
                r_cnt   <= '0;
                r_state <= c_ST_GRANT;
            end
        end else begin
            if (w_release) begin
                r_ptr <= w_next_ptr;
                r_cnt <= '0;
                if (w_pick_found) begin
                    r_owner <= w_pick_idx;
                end else begin
                    r_state <= c_ST_IDLE;
                end
            end else if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_busy  = w_grant;
    assign o_valid = w_grant && w_own_req;
    assign o_data  = w_grant ? w_data[r_owner] : '0;
    assign o_owner = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_svi_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_svi_rr_scheduler
// Brief  : Directed self-checking bench for svi_rr_scheduler (8 req, burst 4).
// Rev    : 1.0  initial release
// ============================================================================
module tb_svi_rr_scheduler;

    logic       clk = 1'b0;
    logic       arst_n;
    logic [7:0] req;
    logic [7:0] data [8];
    logic       ready;
    logic [7:0] gnt;
    logic [7:0] ack;
    logic       o_valid;
    logic [7:0] o_data;
    logic [2:0] o_owner;
    logic       o_busy;
    logic [28:0] obs;
    logic [28:0] exp_v;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    R #(.W_DATA(8)) bus [8] ();

    for (genvar g = 0; g < 8; g++) begin : g_conn
        assign bus[g].req  = req[g];
        assign bus[g].data = data[g];
        assign gnt[g]      = bus[g].gnt;
        assign ack[g]      = bus[g].ack;
    end

    svi_rr_scheduler #(.N_REQ(8), .W_DATA(8), .MAX_BURST(4)) dut (
        .i_clk    (clk),
        .i_arst_n (arst_n),
        .p        (bus),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .i_ready  (ready),
        .o_owner  (o_owner),
        .o_busy   (o_busy)
    );

    assign obs = {gnt, ack, o_valid, o_busy, o_owner, o_data};

    function automatic logic [28:0] ev(input logic [7:0] g, input logic [7:0] a,
                                       input logic v, input logic b,
                                       input logic [2:0] o, input logic [7:0] d);
        return {g, a, v, b, o, d};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        arst_n = 1'b1;
        #1;
        arst_n = 1'b0;
        req    = '0;
        ready  = 1'b0;
        for (int i = 0; i < 8; i++) data[i] = 8'hA0 + 8'(i);
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        @(negedge clk);
        exp_v = ev(8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs, exp_v); end
        tick();
        req = 8'h02; ready = 1'b1; data[1] = 8'h11;
        @(negedge clk);
        exp_v = ev(8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL reset_latency got=%h exp=%h", obs, exp_v); end
        tick();
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            exp_v = ev(8'h02, 8'h02, 1'b1, 1'b1, 3'd1, 8'h11);
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL reset_beat b=%0d got=%h exp=%h", b, obs, exp_v); end
            tick();
        end
        #2;
        arst_n = 1'b0;
        #1;
        exp_v = ev(8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL reset_async got=%h exp=%h", obs, exp_v); end
        req = 8'h01;
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        @(negedge clk);
        exp_v = ev(8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL reset_release_idle got=%h exp=%h", obs, exp_v); end
        tick();
        @(negedge clk);
        exp_v = ev(8'h01, 8'h01, 1'b1, 1'b1, 3'd0, 8'hA0);
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL reset_regrant got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_sole_burst;
        do_reset();
        req = 8'h08; ready = 1'b1; data[3] = 8'h33;
        @(negedge clk);
        exp_v = ev(8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL sole_pre got=%h exp=%h", obs, exp_v); end
        tick();
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            exp_v = ev(8'h08, 8'h08, 1'b1, 1'b1, 3'd3, 8'h33);
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL sole_beat b=%0d got=%h exp=%h", b, obs, exp_v); end
            tick();
        end
        req = 8'h00;
        @(negedge clk);
        exp_v = ev(8'h08, 8'h00, 1'b0, 1'b1, 3'd3, 8'h33);
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL sole_drop got=%h exp=%h", obs, exp_v); end
        tick();
        @(negedge clk);
        exp_v = ev(8'h00, 8'h00, 1'b0, 1'b0, 3'd3, 8'h00);
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL sole_idle got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_all_rotate;
        int nacks [8];
        int own;
        for (int i = 0; i < 8; i++) nacks[i] = 0;
        do_reset();
        req = 8'hFF; ready = 1'b1;
        tick();
        for (int g = 0; g < 9; g++) begin
            for (int b = 0; b < 4; b++) begin
                own = g % 8;
                @(negedge clk);
                exp_v = ev(8'h01 << own, 8'h01 << own, 1'b1, 1'b1, 3'(own), 8'hA0 + 8'(own));
                checks++;
                if (obs !== exp_v) begin failures++; $display("FAIL rotate g=%0d b=%0d got=%h exp=%h", g, b, obs, exp_v); end
                if (g < 8) begin
                    for (int i = 0; i < 8; i++) if (ack[i]) nacks[i]++;
                end
                tick();
            end
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (nacks[i] !== 4) begin failures++; $display("FAIL rotate_acks req=%0d got=%0d exp=4", i, nacks[i]); end
        end
        req = 8'h00;
    endtask

    task automatic test_stall;
        do_reset();
        req = 8'h0C; ready = 1'b0;
        tick();
        for (int s = 0; s < 5; s++) begin
            data[2] = 8'h50 + 8'(s);
            @(negedge clk);
            exp_v = ev(8'h04, 8'h00, 1'b1, 1'b1, 3'd2, 8'h50 + 8'(s));
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL stall s=%0d got=%h exp=%h", s, obs, exp_v); end
            tick();
        end
        ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            exp_v = ev(8'h04, 8'h04, 1'b1, 1'b1, 3'd2, 8'h54);
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL stall_beat b=%0d got=%h exp=%h", b, obs, exp_v); end
            tick();
        end
        @(negedge clk);
        exp_v = ev(8'h08, 8'h08, 1'b1, 1'b1, 3'd3, 8'hA3);
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL stall_next got=%h exp=%h", obs, exp_v); end
        req = 8'h00;
    endtask

    task automatic test_wrap;
        do_reset();
        req = 8'h80; ready = 1'b1; data[7] = 8'h77;
        tick();
        req = 8'hC1;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            exp_v = ev(8'h80, 8'h80, 1'b1, 1'b1, 3'd7, 8'h77);
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL wrap_own7 b=%0d got=%h exp=%h", b, obs, exp_v); end
            tick();
        end
        req = 8'h41;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            exp_v = ev(8'h01, 8'h01, 1'b1, 1'b1, 3'd0, 8'hA0);
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL wrap_own0 b=%0d got=%h exp=%h", b, obs, exp_v); end
            tick();
        end
        @(negedge clk);
        exp_v = ev(8'h40, 8'h40, 1'b1, 1'b1, 3'd6, 8'hA6);
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL wrap_own6 got=%h exp=%h", obs, exp_v); end
        req = 8'h00;
    endtask

    task automatic test_back_to_back;
        do_reset();
        req = 8'h02; ready = 1'b1; data[1] = 8'h11;
        tick();
        req = 8'h62;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            exp_v = ev(8'h02, 8'h02, 1'b1, 1'b1, 3'd1, 8'h11);
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL b2b_own1 b=%0d got=%h exp=%h", b, obs, exp_v); end
            tick();
        end
        req = 8'h60;
        @(negedge clk);
        exp_v = ev(8'h02, 8'h00, 1'b0, 1'b1, 3'd1, 8'h11);
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL b2b_drop got=%h exp=%h", obs, exp_v); end
        tick();
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            exp_v = ev(8'h20, 8'h20, 1'b1, 1'b1, 3'd5, 8'hA5);
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL b2b_own5 b=%0d got=%h exp=%h", b, obs, exp_v); end
            tick();
        end
        @(negedge clk);
        exp_v = ev(8'h40, 8'h40, 1'b1, 1'b1, 3'd6, 8'hA6);
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL b2b_own6 got=%h exp=%h", obs, exp_v); end
        req = 8'h00;
    endtask

    initial begin
        arst_n = 1'b0;
        req    = '0;
        ready  = 1'b0;
        for (int i = 0; i < 8; i++) data[i] = '0;
        test_reset();
        test_sole_burst();
        test_all_rotate();
        test_stall();
        test_wrap();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
